// File: rtl/fetch_sequencer_pkg.sv
// Shared types and default sizing for the fetch sequencer slice.
// The package is named fetch_pkg because the top and the interface import it by that name.
package fetch_pkg;
    localparam int DEF_PW = 10;
    localparam int DEF_IW = 9;
    localparam int DEF_SD = 4;
    localparam int DEF_CW = 16;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, HALT} fetch_state_e;
endpackage

// File: rtl/fetch_sequencer_if.sv
// Control/status bundle between the sequencer and its driver (decoder or bench).
interface fetch_sequencer_if import fetch_pkg::*; #(
    parameter int PW = DEF_PW,
    parameter int IW = DEF_IW,
    parameter int CW = DEF_CW
);
    logic          Start;
    logic          Stall;
    logic [IW-1:0] Instruction;
    logic          Jump;
    logic          Call;
    logic          Ret;
    logic          BranchEn;
    logic          Flag;
    logic [PW-1:0] Target;
    logic [PW-1:0] ProgCtr;
    logic          Ack;
    logic [CW-1:0] CycleCt;
    logic          StackErr;

    modport master (
        output Start, Stall, Instruction, Jump, Call, Ret, BranchEn, Flag, Target,
        input  ProgCtr, Ack, CycleCt, StackErr
    );
    modport slave (
        input  Start, Stall, Instruction, Jump, Call, Ret, BranchEn, Flag, Target,
        output ProgCtr, Ack, CycleCt, StackErr
    );
endinterface

// File: rtl/fetch_sequencer_ret_stack.sv
// Return-address LIFO. Entries are unreset storage; only the pointer is reset.
// The top never issues Push and Pop together, so Push simply wins here.
module ret_stack #(
    parameter int SD = 4,
    parameter int PW = 10
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Clear,
    input  logic          Push,
    input  logic          Pop,
    input  logic [PW-1:0] PushData,
    output logic [PW-1:0] Top,
    output logic          Full,
    output logic          Empty
);
    localparam int SPW = $clog2(SD + 1);
    localparam int AW  = $clog2(SD);

    logic [SPW-1:0] sp;
    logic [PW-1:0]  mem [SD];
    logic [AW-1:0]  topIdx;

    assign Full   = (sp == SPW'(SD));
    assign Empty  = (sp == '0);
    assign topIdx = sp[AW-1:0] - AW'(1);
    assign Top    = mem[topIdx];

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)              sp <= '0;
        else if (Clear)          sp <= '0;
        else if (Push && !Full)  sp <= sp + SPW'(1);
        else if (Pop && !Empty)  sp <= sp - SPW'(1);
    end

    always_ff @(posedge Clk) begin
        if (Push && !Full && !Clear) mem[sp[AW-1:0]] <= PushData;
    end
endmodule

// File: rtl/fetch_sequencer.sv
// Program-counter sequencer: IDLE/LOAD/RUN/HALT FSM with jump, call/return,
// relative branch, stall, halt detection and a saturating cycle counter.
module fetch_sequencer import fetch_pkg::*; #(
    parameter int PW = DEF_PW,
    parameter int IW = DEF_IW,
    parameter int SD = DEF_SD,
    parameter int CW = DEF_CW
) (
    input  logic Clk,
    input  logic Reset,
    fetch_sequencer_if.slave bus
);
    localparam logic [PW-1:0] PC_ONE = PW'(1);
    localparam logic [CW-1:0] CT_ONE = CW'(1);

    fetch_state_e  state, nextState;
    logic [PW-1:0] progCtr, nextPc;
    logic [CW-1:0] cycleCt, nextCt;
    logic          stackErr, nextErr, ack;
    logic          pushEn, popEn, clearStack;
    logic [PW-1:0] stackTop;
    logic          stackFull, stackEmpty;
    logic [IW-1:0] instr;
    logic          haltInstr;

    assign instr     = bus.Instruction;
    assign haltInstr = &instr;

    ret_stack #(.SD(SD), .PW(PW)) uStack (
        .Clk      (Clk),
        .Reset    (Reset),
        .Clear    (clearStack),
        .Push     (pushEn),
        .Pop      (popEn),
        .PushData (progCtr + PC_ONE),
        .Top      (stackTop),
        .Full     (stackFull),
        .Empty    (stackEmpty)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) state <= IDLE;
        else        state <= nextState;
    end

    // Halt beats stall, and stall beats every control input.
    always_comb begin
        nextState  = state;
        nextPc     = progCtr;
        nextCt     = cycleCt;
        nextErr    = stackErr;
        pushEn     = 1'b0;
        popEn      = 1'b0;
        clearStack = 1'b0;
        if (bus.Start) begin
            nextState  = LOAD;
            nextPc     = '0;
            nextCt     = '0;
            nextErr    = 1'b0;
            clearStack = 1'b1;
        end else begin
            case (state)
                LOAD: nextState = RUN;
                RUN: begin
                    if (cycleCt != '1) nextCt = cycleCt + CT_ONE;
                    if (haltInstr) begin
                        nextState = HALT;
                    end else if (!bus.Stall) begin
                        if (bus.Jump) begin
                            nextPc = bus.Target;
                        end else if (bus.Call) begin
                            if (stackFull) begin
                                nextState = HALT;
                                nextErr   = 1'b1;
                            end else begin
                                pushEn = 1'b1;
                                nextPc = bus.Target;
                            end
                        end else if (bus.Ret) begin
                            if (stackEmpty) begin
                                nextState = HALT;
                                nextErr   = 1'b1;
                            end else begin
                                popEn  = 1'b1;
                                nextPc = stackTop;
                            end
                        end else if (bus.BranchEn && bus.Flag) begin
                            nextPc = progCtr + bus.Target;
                        end else begin
                            nextPc = progCtr + PC_ONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            progCtr  <= '0;
            cycleCt  <= '0;
            stackErr <= 1'b0;
            ack      <= 1'b0;
        end else begin
            progCtr  <= nextPc;
            cycleCt  <= nextCt;
            stackErr <= nextErr;
            ack      <= (nextState == HALT);
        end
    end

    assign bus.ProgCtr  = progCtr;
    assign bus.CycleCt  = cycleCt;
    assign bus.StackErr = stackErr;
    assign bus.Ack      = ack;
endmodule
